// File: rtl/source_run_scheduler.sv
// source_run_scheduler
// Expands compact host commands into the per-cycle source word stream for
// network_source. SPK accumulates saturated charges into a staging buffer,
// RUN n emits n NOM words (the first carries the staged charges), and CLR
// emits a single clear word. Outputs are registered; one bubble cycle
// separates consecutive RUN/CLR commands.

module source_run_scheduler #(
  parameter int NET_NUM_INP      = 4,
  parameter int NET_CHARGE_WIDTH = 8,
  parameter int RUN_WIDTH        = 16,
  parameter int IDX_WIDTH        = (NET_NUM_INP > 1) ? $clog2(NET_NUM_INP) : 1,
  parameter int SRC_WIDTH        = 1 + NET_NUM_INP * NET_CHARGE_WIDTH
) (
  input  logic                        clk,
  input  logic                        arstn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_opc,
  input  logic [RUN_WIDTH-1:0]        cmd_run,
  input  logic [IDX_WIDTH-1:0]        cmd_idx,
  input  logic [NET_CHARGE_WIDTH-1:0] cmd_charge,
  output logic                        src_valid,
  input  logic                        src_ready,
  output logic [SRC_WIDTH-1:0]        src,
  output logic                        busy,
  output logic                        run_done
);

  localparam int CW = NET_CHARGE_WIDTH;

  localparam logic [1:0] OPC_SPK = 2'd0;
  localparam logic [1:0] OPC_RUN = 2'd1;
  localparam logic [1:0] OPC_CLR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CLR  = 2'd2
  } state_t;

  state_t                              state_r, state_nxt_s;
  logic [RUN_WIDTH-1:0]                cnt_r, cnt_nxt_s;
  logic [NET_NUM_INP-1:0][CW-1:0]      stage_r, stage_nxt_s;
  logic [SRC_WIDTH-1:0]                src_r, src_nxt_s;
  logic                                src_valid_r, src_valid_nxt_s;
  logic                                run_done_r, run_done_nxt_s;
  logic                                cmd_ready_r;
  logic                                busy_r;
  logic                                hs_s;
  logic                                accept_s;
  logic [SRC_WIDTH-1:0]                stage_word_s;

  // Signed add clamped to the representable charge range.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b);
    logic [CW:0] sum;
    sum = {a[CW-1], a} + {b[CW-1], b};
    if (sum[CW] != sum[CW-1]) begin
      sat_add = sum[CW] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
    end else begin
      sat_add = sum[CW-1:0];
    end
  endfunction

  assign hs_s     = src_valid_r && src_ready;
  assign accept_s = cmd_valid && cmd_ready_r;

  // Pack the staging buffer into a NOM word; input 0 sits just below the opcode.
  always_comb begin
    stage_word_s = '0;
    for (int i = 0; i < NET_NUM_INP; i++) begin
      stage_word_s[SRC_WIDTH-2-i*CW -: CW] = stage_r[i];
    end
  end

  // Next-state and next-output logic for the command/run sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    stage_nxt_s     = stage_r;
    src_nxt_s       = src_r;
    src_valid_nxt_s = src_valid_r;
    run_done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd_opc)
            OPC_SPK: begin
              // Out-of-range indices match no slot and are dropped.
              for (int i = 0; i < NET_NUM_INP; i++) begin
                if (cmd_idx == IDX_WIDTH'(i)) begin
                  stage_nxt_s[i] = sat_add(stage_r[i], cmd_charge);
                end else begin
                  stage_nxt_s[i] = stage_r[i];
                end
              end
            end
            OPC_RUN: begin
              if (cmd_run != {RUN_WIDTH{1'b0}}) begin
                cnt_nxt_s       = cmd_run;
                state_nxt_s     = ST_RUN;
                src_nxt_s       = stage_word_s;
                src_valid_nxt_s = 1'b1;
              end else begin
                run_done_nxt_s  = 1'b1;
              end
            end
            OPC_CLR: begin
              stage_nxt_s     = '0;
              state_nxt_s     = ST_CLR;
              src_nxt_s       = {1'b1, {(SRC_WIDTH-1){1'b0}}};
              src_valid_nxt_s = 1'b1;
            end
            default: begin
              state_nxt_s = ST_IDLE;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hs_s) begin
          // The staged charges left with the first word; later words are blank.
          stage_nxt_s = '0;
          cnt_nxt_s   = cnt_r - RUN_WIDTH'(1);
          src_nxt_s   = '0;
          if (cnt_r == RUN_WIDTH'(1)) begin
            state_nxt_s     = ST_IDLE;
            src_valid_nxt_s = 1'b0;
            run_done_nxt_s  = 1'b1;
          end else begin
            src_valid_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_CLR: begin
        if (hs_s) begin
          state_nxt_s     = ST_IDLE;
          src_nxt_s       = '0;
          src_valid_nxt_s = 1'b0;
          run_done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_CLR;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        src_nxt_s       = '0;
        src_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and registered outputs; ready/busy track the next state so they
  // stay free of any combinational path from src_ready.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt_r       <= '0;
      stage_r     <= '0;
      src_r       <= '0;
      src_valid_r <= 1'b0;
      run_done_r  <= 1'b0;
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      stage_r     <= stage_nxt_s;
      src_r       <= src_nxt_s;
      src_valid_r <= src_valid_nxt_s;
      run_done_r  <= run_done_nxt_s;
      cmd_ready_r <= (state_nxt_s == ST_IDLE);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign src       = src_r;
  assign src_valid = src_valid_r;
  assign run_done  = run_done_r;

endmodule

// File: tb/tb_source_run_scheduler.sv
// Scoreboard bench for source_run_scheduler: commands update a behavioural
// model that queues expected source words; a negedge monitor pops and compares.

module tb_source_run_scheduler;

  localparam int NI  = 4;
  localparam int CW  = 8;
  localparam int RW  = 16;
  localparam int IW  = 3;
  localparam int SW  = 1 + NI * CW;

  logic          clk = 1'b0;
  logic          arstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_opc;
  logic [RW-1:0] cmd_run;
  logic [IW-1:0] cmd_idx;
  logic [CW-1:0] cmd_charge;
  logic          src_valid;
  logic          src_ready;
  logic [SW-1:0] src;
  logic          busy;
  logic          run_done;

  source_run_scheduler #(
    .NET_NUM_INP(NI), .NET_CHARGE_WIDTH(CW), .RUN_WIDTH(RW), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .arstn(arstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opc(cmd_opc), .cmd_run(cmd_run), .cmd_idx(cmd_idx), .cmd_charge(cmd_charge),
    .src_valid(src_valid), .src_ready(src_ready), .src(src), .busy(busy),
    .run_done(run_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] w;
    bit            last;
  } exp_t;

  exp_t q[$];
  int   stage_m[NI];
  int   checks = 0;
  int   errors = 0;
  int   hs_count = 0;
  bit   mon_en = 1'b0;
  bit   run0_flag = 1'b0;
  bit   prev_final = 1'b0;
  bit   prev_stall = 1'b0;
  logic [SW-1:0] prev_src;
  bit   ready_mode = 1'b1;
  bit   hold_low = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] make_word(input bit op, input int ch[NI]);
    logic [SW-1:0] w;
    logic [CW-1:0] c;
    w = '0;
    w[SW-1] = op;
    for (int i = 0; i < NI; i++) begin
      c = CW'(ch[i]);
      w[SW-2-i*CW -: CW] = c;
    end
    return w;
  endfunction

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference model: applied when a command is accepted.
  task automatic model_accept(input int opc, input int run, input int idx, input int charge);
    int   zeros[NI];
    exp_t e;
    for (int i = 0; i < NI; i++) zeros[i] = 0;
    case (opc)
      0: if (idx < NI) stage_m[idx] = clamp(stage_m[idx] + charge);
      1: begin
        if (run == 0) begin
          run0_flag = 1'b1;
        end else begin
          for (int k = 0; k < run; k++) begin
            e.w    = (k == 0) ? make_word(1'b0, stage_m) : make_word(1'b0, zeros);
            e.last = (k == run - 1);
            q.push_back(e);
          end
          for (int i = 0; i < NI; i++) stage_m[i] = 0;
        end
      end
      2: begin
        e.w = make_word(1'b1, zeros);
        e.last = 1'b1;
        q.push_back(e);
        for (int i = 0; i < NI; i++) stage_m[i] = 0;
      end
      default: ;
    endcase
  endtask

  task automatic issue(input int opc, input int run, input int idx, input int charge);
    bit acc = 1'b0;
    cmd_opc    = 2'(opc);
    cmd_run    = RW'(run);
    cmd_idx    = IW'(idx);
    cmd_charge = CW'(charge);
    cmd_valid  = 1'b1;
    for (int k = 0; k < 1000 && !acc; k++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (acc) model_accept(opc, run, idx, charge);
    else chk("cmd_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((q.size() != 0 || !cmd_ready) && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 2000) chk("idle_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Sink-side ready generator.
  initial begin
    src_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_low) src_ready = 1'b0;
      else if (ready_mode) src_ready = 1'b1;
      else src_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: checks status outputs and pops expected words on handshakes.
  always @(negedge clk) begin
    exp_t e;
    bit   busy_exp;
    if (!arstn) begin
      prev_final = 1'b0;
      prev_stall = 1'b0;
    end else if (mon_en) begin
      busy_exp = (q.size() != 0);
      chk("busy", 64'(busy), 64'(busy_exp));
      chk("cmd_ready", 64'(cmd_ready), 64'(!busy_exp));
      chk("run_done", 64'(run_done), 64'(prev_final || run0_flag));
      run0_flag  = 1'b0;
      prev_final = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", 64'(src_valid), 64'd1);
        chk("stall_src", 64'(src), 64'(prev_src));
      end
      if (src_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 64'(src), 64'd0);
        end else if (src_ready) begin
          e = q.pop_front();
          chk("src_word", 64'(src), 64'(e.w));
          prev_final = e.last;
          hs_count++;
        end
      end
      prev_stall = src_valid && !src_ready;
      prev_src   = src;
    end
  end

  initial begin
    int hs0;
    int k;
    arstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_opc = 2'd0;
    cmd_run = '0;
    cmd_idx = '0;
    cmd_charge = '0;
    for (int i = 0; i < NI; i++) stage_m[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_src_valid", 64'(src_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_run_done", 64'(run_done), 64'd0);
    chk("rst_src", 64'(src), 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);
    mon_en = 1'b1;

    // Accumulation then a three-word run.
    issue(0, 0, 1, 5);
    issue(0, 0, 1, 7);
    issue(1, 3, 0, 0);
    wait_idle();

    // Saturation in both directions.
    issue(0, 0, 0, 100);
    issue(0, 0, 0, 100);
    issue(0, 0, 2, -100);
    issue(0, 0, 2, -100);
    issue(1, 1, 0, 0);
    wait_idle();

    // Backpressure: three stalled cycles on the first word.
    issue(0, 0, 3, 33);
    hs0 = hs_count;
    hold_low = 1'b1;
    issue(1, 2, 0, 0);
    repeat (3) @(posedge clk);
    hold_low = 1'b0;
    wait_idle();
    chk("bp_handshakes", 64'(hs_count - hs0), 64'd2);

    // Clear discards staged charge; following run is blank.
    issue(0, 0, 3, 9);
    issue(2, 0, 0, 0);
    issue(1, 1, 0, 0);
    wait_idle();

    // RUN 0 leaves staging alone; out-of-range index ignored; reserved opcode.
    issue(0, 0, 0, 3);
    issue(1, 0, 0, 0);
    issue(0, 0, 5, 50);
    issue(3, 7, 1, 1);
    issue(1, 1, 0, 0);
    wait_idle();

    // Reset in the middle of a long run.
    issue(0, 0, 2, 11);
    hs0 = hs_count;
    issue(1, 10, 0, 0);
    k = 0;
    while (hs_count - hs0 < 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("mid_run_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #2;
    arstn = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("mid_rst_src_valid", 64'(src_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_run_done", 64'(run_done), 64'd0);
    chk("mid_rst_src", 64'(src), 64'd0);
    q.delete();
    run0_flag = 1'b0;
    for (int i = 0; i < NI; i++) stage_m[i] = 0;
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_release_ready", 64'(cmd_ready), 64'd1);
    mon_en = 1'b1;
    issue(1, 1, 0, 0);
    wait_idle();

    // Randomized traffic with random sink backpressure.
    ready_mode = 1'b0;
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) issue(0, 0, $urandom_range(0, 7), $urandom_range(0, 255) - 128);
      else if (r < 8) issue(1, $urandom_range(0, 5), 0, 0);
      else if (r < 9) issue(2, 0, 0, 0);
      else issue(3, $urandom_range(0, 5), $urandom_range(0, 7), 0);
    end
    ready_mode = 1'b1;
    wait_idle();
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
